// File: rtl/rpsc_pkg.sv
//==============================================================================
// Module   : rpsc_pkg
// Purpose  : Shared types and constants for the RPSC trip-latch annunciator.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package rpsc_pkg;

   typedef enum logic [1:0] {
      CH_NORMAL    = 2'b00,
      CH_ALM_UNACK = 2'b01,
      CH_ALM_ACK   = 2'b10
   } ch_state_t;

   localparam int RPSC_N_CH    = 8;
   localparam int c_sync_depth = 2;

endpackage : rpsc_pkg

`default_nettype wire

// File: rtl/rpsc_input_qual.sv
//==============================================================================
// Module   : rpsc_input_qual
// Purpose  : One-bit synchronizer plus consecutive-sample debounce filter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rpsc_input_qual
   import rpsc_pkg::*;
#(
   parameter int DEBOUNCE = 4
)(
   input  logic clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_qual
);

   localparam int                  c_CNT_W    = $clog2(DEBOUNCE + 1);
   localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DEBOUNCE - 1);

   logic [c_sync_depth-1:0] r_sync;
   logic [c_CNT_W-1:0]      r_cnt;
   logic                    r_qual;
   logic                    w_sync;

   assign w_sync = r_sync[c_sync_depth-1];
   assign o_qual = r_qual;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[c_sync_depth-2:0], i_raw};
      end
   end

   // Any sample that agrees with the qualified value restarts the count.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt  <= '0;
         r_qual <= 1'b0;
      end else if (w_sync == r_qual) begin
         r_cnt  <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
         r_cnt  <= '0;
         r_qual <= w_sync;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
      end
   end

endmodule : rpsc_input_qual

`default_nettype wire

// File: rtl/rpsc_annunciator_ctrl.sv
//==============================================================================
// Module   : rpsc_annunciator_ctrl
// Purpose  : Trip-latch sequencer for FF17-FF24: alarm latching, ack/reset,
//            flashing lamps, first-out capture, horn and lamp test.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rpsc_annunciator_ctrl
   import rpsc_pkg::*;
#(
   parameter int N_CH      = RPSC_N_CH,
   parameter int DEBOUNCE  = 4,
   parameter int FLASH_DIV = 16
)(
   input  logic                    clk,
   input  logic                    reset_from_card6_n,
   input  logic [N_CH-1:0]         trip_in,
   input  logic                    ack_pb,
   input  logic                    reset_pb,
   input  logic                    lamp_test,
   output logic [N_CH-1:0]         ff_out,
   output logic [N_CH-1:0]         la_out,
   output logic [$clog2(N_CH)-1:0] first_out,
   output logic                    first_out_valid,
   output logic                    horn
);

   localparam int                   c_IDX_W      = $clog2(N_CH);
   localparam int                   c_FLASH_W    = $clog2(FLASH_DIV);
   localparam logic [c_FLASH_W-1:0] c_FLASH_LAST = c_FLASH_W'(FLASH_DIV - 1);

   logic [N_CH-1:0]      w_qual;
   logic                 w_ack_q;
   logic                 w_rst_q;
   logic                 w_lt;
   logic                 r_ack_d;
   logic                 r_rst_d;
   logic                 w_ack_p;
   logic                 w_rst_p;

   logic [c_FLASH_W-1:0] r_flash_cnt;
   logic                 r_flash_phase;
   logic                 w_flash_phase_nxt;

   ch_state_t            r_state     [N_CH];
   ch_state_t            w_state_nxt [N_CH];
   logic [N_CH-1:0]      w_nxt_unack;
   logic [N_CH-1:0]      w_nxt_ack;
   logic [N_CH-1:0]      w_entering;
   logic [c_IDX_W-1:0]   w_first_idx;

   logic [N_CH-1:0]      r_ff_out;
   logic [N_CH-1:0]      r_la_out;
   logic [c_IDX_W-1:0]   r_first_out;
   logic                 r_first_valid;
   logic                 r_horn;

   //---------------------------------------------------------------------------
   // Input qualification
   //---------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_trip_qual
         rpsc_input_qual #(.DEBOUNCE(DEBOUNCE)) u_trip_qual (
            .clk     (clk),
            .i_rst_n (reset_from_card6_n),
            .i_raw   (trip_in[gi]),
            .o_qual  (w_qual[gi])
         );
      end
   endgenerate

   rpsc_input_qual #(.DEBOUNCE(1)) u_ack_qual (
      .clk     (clk),
      .i_rst_n (reset_from_card6_n),
      .i_raw   (ack_pb),
      .o_qual  (w_ack_q)
   );

   rpsc_input_qual #(.DEBOUNCE(1)) u_rst_qual (
      .clk     (clk),
      .i_rst_n (reset_from_card6_n),
      .i_raw   (reset_pb),
      .o_qual  (w_rst_q)
   );

   rpsc_input_qual #(.DEBOUNCE(1)) u_lt_qual (
      .clk     (clk),
      .i_rst_n (reset_from_card6_n),
      .i_raw   (lamp_test),
      .o_qual  (w_lt)
   );

   always_ff @(posedge clk or negedge reset_from_card6_n) begin
      if (!reset_from_card6_n) begin
         r_ack_d <= 1'b0;
         r_rst_d <= 1'b0;
      end else begin
         r_ack_d <= w_ack_q;
         r_rst_d <= w_rst_q;
      end
   end

   assign w_ack_p = w_ack_q & ~r_ack_d;
   assign w_rst_p = w_rst_q & ~r_rst_d;

   //---------------------------------------------------------------------------
   // Flash generator
   //---------------------------------------------------------------------------
   assign w_flash_phase_nxt = (r_flash_cnt == c_FLASH_LAST) ? ~r_flash_phase : r_flash_phase;

   always_ff @(posedge clk or negedge reset_from_card6_n) begin
      if (!reset_from_card6_n) begin
         r_flash_cnt   <= '0;
         r_flash_phase <= 1'b1;
      end else begin
         r_flash_cnt   <= (r_flash_cnt == c_FLASH_LAST) ? '0 : r_flash_cnt + 1'b1;
         r_flash_phase <= w_flash_phase_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Channel FSMs
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_from_card6_n) begin
      if (!reset_from_card6_n) begin
         for (int i = 0; i < N_CH; i++) begin
            r_state[i] <= CH_NORMAL;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            r_state[i] <= w_state_nxt[i];
         end
      end
   end

   // Ack wins over reset in the same cycle, so a freshly acked channel
   // always needs a later reset press to clear.
   always_comb begin
      w_nxt_unack = '0;
      w_nxt_ack   = '0;
      w_entering  = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_state_nxt[i] = r_state[i];
         case (r_state[i])
            CH_NORMAL: begin
               if (w_qual[i]) begin
                  w_state_nxt[i] = CH_ALM_UNACK;
               end
            end
            CH_ALM_UNACK: begin
               if (w_ack_p) begin
                  w_state_nxt[i] = CH_ALM_ACK;
               end
            end
            CH_ALM_ACK: begin
               if (w_rst_p && !w_ack_p && !w_qual[i]) begin
                  w_state_nxt[i] = CH_NORMAL;
               end
            end
            default: w_state_nxt[i] = CH_NORMAL;
         endcase
         w_nxt_unack[i] = (w_state_nxt[i] == CH_ALM_UNACK);
         w_nxt_ack[i]   = (w_state_nxt[i] == CH_ALM_ACK);
         w_entering[i]  = (r_state[i] == CH_NORMAL) && (w_state_nxt[i] == CH_ALM_UNACK);
      end
   end

   always_comb begin
      w_first_idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (w_entering[i]) begin
            w_first_idx = c_IDX_W'(i);
         end
      end
   end

   //---------------------------------------------------------------------------
   // Registered outputs, driven from next state so they land with the FSM edge
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_from_card6_n) begin
      if (!reset_from_card6_n) begin
         r_ff_out      <= '0;
         r_la_out      <= '0;
         r_horn        <= 1'b0;
         r_first_out   <= '0;
         r_first_valid <= 1'b0;
      end else begin
         r_ff_out <= w_nxt_unack | w_nxt_ack;
         r_horn   <= |w_nxt_unack;
         r_la_out <= w_lt ? '1 : (w_nxt_ack | (w_nxt_unack & {N_CH{w_flash_phase_nxt}}));
         if (!r_first_valid) begin
            if (|w_entering) begin
               r_first_out   <= w_first_idx;
               r_first_valid <= 1'b1;
            end
         end else if (!(|(w_nxt_unack | w_nxt_ack))) begin
            r_first_out   <= '0;
            r_first_valid <= 1'b0;
         end
      end
   end

   assign ff_out          = r_ff_out;
   assign la_out          = r_la_out;
   assign horn            = r_horn;
   assign first_out       = r_first_out;
   assign first_out_valid = r_first_valid;

endmodule : rpsc_annunciator_ctrl

`default_nettype wire

// File: tb/tb_rpsc_annunciator_ctrl.sv
//==============================================================================
// Module   : tb_rpsc_annunciator_ctrl
// Purpose  : Self-checking bench for the RPSC annunciator sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rpsc_annunciator_ctrl;

   localparam int N_CH = 8;
   localparam int DEB  = 4;
   localparam int FDIV = 16;

   logic            clk;
   logic            rst_n;
   logic [N_CH-1:0] trip_in;
   logic            ack_pb;
   logic            reset_pb;
   logic            lamp_test;
   logic [N_CH-1:0] ff_out;
   logic [N_CH-1:0] la_out;
   logic [2:0]      first_out;
   logic            first_out_valid;
   logic            horn;

   int          checks;
   int          errors;
   int unsigned edges;

   rpsc_annunciator_ctrl #(.N_CH(N_CH), .DEBOUNCE(DEB), .FLASH_DIV(FDIV)) dut (
      .clk                (clk),
      .reset_from_card6_n (rst_n),
      .trip_in            (trip_in),
      .ack_pb             (ack_pb),
      .reset_pb           (reset_pb),
      .lamp_test          (lamp_test),
      .ff_out             (ff_out),
      .la_out             (la_out),
      .first_out          (first_out),
      .first_out_valid    (first_out_valid),
      .horn               (horn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clock edges seen since reset release; the flash phase follows from it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges <= 0;
      else        edges <= edges + 1;
   end

   function automatic logic exp_phase();
      return ((edges / FDIV) % 2) == 0;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic a, input logic r);
      ack_pb   = a;
      reset_pb = r;
      tick(3);
      ack_pb   = 1'b0;
      reset_pb = 1'b0;
      tick(8);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; trip_in = '1; ack_pb = 0; reset_pb = 0; lamp_test = 0;
      tick(4);
      checks++;
      if ({ff_out, la_out, first_out, first_out_valid, horn} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ff=%h la=%h fo=%0d v=%b horn=%b, want all 0",
                  ff_out, la_out, first_out, first_out_valid, horn);
      end
      trip_in = '0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_latency();
      trip_in[2] = 1'b1;
      repeat (DEB + 2) @(posedge clk);
      #1;
      checks++;
      if (ff_out !== 8'h00) begin
         errors++;
         $display("FAIL latency_early: ff_out=%h want 00", ff_out);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ff_out !== 8'h04 || horn !== 1'b1) begin
         errors++;
         $display("FAIL latency_edge: ff_out=%h horn=%b want 04/1", ff_out, horn);
      end
      checks++;
      if (first_out !== 3'd2 || first_out_valid !== 1'b1) begin
         errors++;
         $display("FAIL first_out_basic: fo=%0d v=%b want 2/1", first_out, first_out_valid);
      end
   endtask

   task automatic test_flash();
      for (int k = 0; k < 3 * FDIV; k++) begin
         @(negedge clk);
         checks++;
         if (la_out[2] !== exp_phase() || la_out[7:3] !== '0 || la_out[1:0] !== '0) begin
            errors++;
            $display("FAIL flash_ch2: la_out=%h want bit2=%b others 0 (edge %0d)",
                     la_out, exp_phase(), edges);
         end
      end
   endtask

   task automatic test_glitch();
      trip_in[5] = 1'b1; tick(DEB - 1); trip_in[5] = 1'b0; tick(12);
      checks++;
      if (ff_out !== 8'h04) begin
         errors++;
         $display("FAIL glitch_reject: ff_out=%h want 04", ff_out);
      end
      trip_in[5] = 1'b1; tick(DEB); trip_in[5] = 1'b0; tick(12);
      checks++;
      if (ff_out !== 8'h24 || first_out !== 3'd2) begin
         errors++;
         $display("FAIL glitch_stable: ff_out=%h fo=%0d want 24/2", ff_out, first_out);
      end
   endtask

   task automatic test_ack_reset();
      trip_in[2] = 1'b0; tick(12);
      press(1'b0, 1'b1);
      checks++;
      if (ff_out !== 8'h24 || horn !== 1'b1) begin
         errors++;
         $display("FAIL reset_while_unack: ff_out=%h horn=%b want 24/1", ff_out, horn);
      end
      press(1'b1, 1'b0);
      checks++;
      if (la_out !== 8'h24 || horn !== 1'b0 || ff_out !== 8'h24) begin
         errors++;
         $display("FAIL ack: la=%h horn=%b ff=%h want 24/0/24", la_out, horn, ff_out);
      end
      press(1'b0, 1'b1);
      checks++;
      if (ff_out !== 8'h00 || first_out_valid !== 1'b0 || first_out !== 3'd0 || la_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_clear: ff=%h v=%b fo=%0d la=%h want 00/0/0/00",
                  ff_out, first_out_valid, first_out, la_out);
      end
   endtask

   task automatic test_simultaneous();
      trip_in = 8'h42; tick(12);
      checks++;
      if (first_out !== 3'd1 || first_out_valid !== 1'b1 || ff_out !== 8'h42) begin
         errors++;
         $display("FAIL simul_first_out: fo=%0d v=%b ff=%h want 1/1/42", first_out, first_out_valid, ff_out);
      end
      trip_in = 8'h40; tick(12);
      press(1'b1, 1'b1);
      checks++;
      if (ff_out !== 8'h42 || horn !== 1'b0 || la_out !== 8'h42) begin
         errors++;
         $display("FAIL ack_and_reset: ff=%h horn=%b la=%h want 42/0/42", ff_out, horn, la_out);
      end
      press(1'b0, 1'b1);
      checks++;
      if (ff_out !== 8'h40 || first_out !== 3'd1 || first_out_valid !== 1'b1) begin
         errors++;
         $display("FAIL standing_trip: ff=%h fo=%0d v=%b want 40/1/1", ff_out, first_out, first_out_valid);
      end
      trip_in = 8'h00; tick(12);
      press(1'b0, 1'b1);
      checks++;
      if (ff_out !== 8'h00 || first_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL standing_clear: ff=%h v=%b want 00/0", ff_out, first_out_valid);
      end
   endtask

   task automatic test_lamp_test();
      trip_in = 8'h08; tick(12);
      lamp_test = 1'b1; tick(6);
      checks++;
      if (la_out !== 8'hFF || ff_out !== 8'h08 || horn !== 1'b1) begin
         errors++;
         $display("FAIL lamp_test_on: la=%h ff=%h horn=%b want FF/08/1", la_out, ff_out, horn);
      end
      lamp_test = 1'b0; tick(6);
      checks++;
      if (la_out !== {4'h0, exp_phase(), 3'b000}) begin
         errors++;
         $display("FAIL lamp_test_off: la=%h want bit3=%b others 0", la_out, exp_phase());
      end
   endtask

   task automatic test_async_reset();
      trip_in = 8'h89; tick(12);
      checks++;
      if (ff_out !== 8'h89) begin
         errors++;
         $display("FAIL three_latched: ff=%h want 89", ff_out);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ff_out, la_out, first_out, first_out_valid, horn} !== '0) begin
         errors++;
         $display("FAIL async_reset: ff=%h la=%h fo=%0d v=%b horn=%b want all 0",
                  ff_out, la_out, first_out, first_out_valid, horn);
      end
      trip_in = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick(20);
      checks++;
      if ({ff_out, la_out, first_out_valid, horn} !== '0) begin
         errors++;
         $display("FAIL after_async_reset: ff=%h la=%h v=%b horn=%b want all 0",
                  ff_out, la_out, first_out_valid, horn);
      end
   endtask

   // Model: 'alarm' = latched channels, 'acked' = latched and acknowledged.
   task automatic test_random();
      logic [N_CH-1:0] alarm, acked, fresh, clr, exp_la;
      logic [2:0]      fo;
      logic            fo_v;
      int              op;
      alarm = '0; acked = '0; fo = '0; fo_v = 1'b0;
      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(0, 4));
         case (op)
            0: begin
               trip_in = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
               tick(DEB + 8);
            end
            1: begin
               trip_in = trip_in & 8'($urandom_range(0, 255));
               tick(DEB + 8);
            end
            2: press(1'b1, 1'b0);
            3: press(1'b0, 1'b1);
            default: press(1'b1, 1'b1);
         endcase
         fresh = trip_in & ~alarm;
         if (op <= 1) begin
            alarm = alarm | fresh;
            if (!fo_v && fresh != 0) begin
               fo_v = 1'b1;
               for (int i = 0; i < N_CH; i++) begin
                  if (fresh[i]) begin fo = 3'(i); break; end
               end
            end
         end else if (op == 2 || op == 4) begin
            acked = alarm;
         end else begin
            clr   = alarm & acked & ~trip_in;
            alarm = alarm & ~clr;
            acked = acked & ~clr;
         end
         if (alarm == 0) begin fo_v = 1'b0; fo = '0; end
         exp_la = (alarm & acked) | ((alarm & ~acked) & {N_CH{exp_phase()}});
         checks++;
         if (ff_out !== alarm || horn !== |(alarm & ~acked)) begin
            errors++;
            $display("FAIL rand_ff_horn[%0d]: ff=%h horn=%b want %h/%b", n, ff_out, horn, alarm, |(alarm & ~acked));
         end
         checks++;
         if (la_out !== exp_la) begin
            errors++;
            $display("FAIL rand_la[%0d]: la=%h want %h", n, la_out, exp_la);
         end
         checks++;
         if (first_out !== fo || first_out_valid !== fo_v) begin
            errors++;
            $display("FAIL rand_first_out[%0d]: fo=%0d v=%b want %0d/%b", n, first_out, first_out_valid, fo, fo_v);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_latency();
      test_flash();
      test_glitch();
      test_ack_reset();
      test_simultaneous();
      test_lamp_test();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_rpsc_annunciator_ctrl

`default_nettype wire

// File: doc/rpsc_annunciator_ctrl.md
Name: rpsc_annunciator_ctrl

Overview:
Sequencer for the eight trip-latch channels FF17–FF24 of the RPSC protection card. It qualifies the raw trip inputs and holds each channel in a latched alarm state until an operator acknowledges and then resets it. It drives the latched flip-flop outputs and the flashing or steady lamp (LA) outputs. It also captures first-out, drives the horn, and supports lamp test.

Parameters:
N_CH, 8, number of trip channels (bit i = FF(17+i))
DEBOUNCE, 4, consecutive stable cycles before the qualified input changes; must be >= 1
FLASH_DIV, 16, cycles per flash half-period; must be >= 2

Ports:
clk  input  1  system clock
reset_from_card6_n  input  1  asynchronous, active-low reset from card 6
trip_in  input  N_CH  raw trip inputs; asynchronous
ack_pb  input  1  operator acknowledge pushbutton; asynchronous level
reset_pb  input  1  operator reset pushbutton; asynchronous level
lamp_test  input  1  lamp test; asynchronous level
ff_out  output  N_CH  latched trip state; 1 = channel not NORMAL
la_out  output  N_CH  lamp drive
first_out  output  $clog2(N_CH)  index of the first channel to alarm
first_out_valid  output  1  first_out holds a captured index
horn  output  1  1 while any channel is ALM_UNACK

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_from_card6_n, asynchronous and active-low.
- While reset is asserted:
  - all channels go to NORMAL;
  - synchronizers, debounce counters and qualified inputs clear to 0;
  - the flash counter clears to 0 and the flash phase is set to 1 (lit);
  - all outputs are 0.
- A reset asserted mid-operation discards every latched alarm, and first-out is lost.
- Input path, per channel:
  - 2-flop synchronizer.
  - Debounce counter of width $clog2(DEBOUNCE+1): qual_i changes only after the synchronized value has differed from qual_i for DEBOUNCE consecutive cycles.
  - The counter clears on any cycle where the synchronized value equals qual_i.
- Pushbuttons: ack_pb and reset_pb each pass through a 2-flop synchronizer and a rising-edge detector, giving one-cycle pulses ack_p and rst_p. Holding a button down yields one pulse only.
- lamp_test is 2-flop synchronized and used as a level.
- Channel FSM states (ch_state_t):
  - NORMAL -> ALM_UNACK when qual_i = 1.
  - ALM_UNACK -> ALM_ACK on ack_p. If qual_i returns to 0, the channel stays in ALM_UNACK (latched). rst_p is ignored in this state.
  - ALM_ACK -> NORMAL on rst_p only if qual_i = 0. rst_p with qual_i = 1 is ignored.
  - ack_p and rst_p in the same cycle: ack is applied and rst is ignored for that cycle. A channel moving ALM_UNACK -> ALM_ACK therefore needs a later rst_p to clear.
  - ack_p is global and applies to all channels in ALM_UNACK in that cycle.
- Latency: ff_out_i rises DEBOUNCE+3 clk edges after trip_in_i rises (2 sync + DEBOUNCE + 1 FSM register). The same latency applies to la_out.
- Outputs (all registered):
  - ff_out_i = (state_i != NORMAL).
  - la_out_i = 1 if lamp_test is active.
  - Otherwise la_out_i = flash_phase in ALM_UNACK, 1 in ALM_ACK, and 0 in NORMAL.
  - lamp_test does not affect FSMs, ff_out or horn.
- Flash generation: a free-running counter over 0..FLASH_DIV-1 toggles flash_phase on wrap, giving a period of 2*FLASH_DIV cycles.
- First-out capture:
  - While first_out_valid = 0, the first cycle in which any channel enters ALM_UNACK loads the lowest index among the channels entering that cycle, and sets valid.
  - Once valid, first_out holds until every channel is NORMAL; valid then clears in the same cycle the last channel returns.
  - first_out = 0 whenever valid = 0.
- horn = OR over channels of (state == ALM_UNACK), registered.

Decomposition:
- Package rpsc_pkg holds:
  - typedef enum logic [1:0] ch_state_t {CH_NORMAL = 2'b00, CH_ALM_UNACK = 2'b01, CH_ALM_ACK = 2'b10};
  - localparam RPSC_N_CH = 8;
  - a sync_depth constant = 2.
- Sub-module rpsc_input_qual contains the synchronizer and debounce for one bit, parameterised by DEBOUNCE.
  - It is instantiated N_CH times, with one further instance for each of ack_pb, reset_pb and lamp_test using DEBOUNCE = 1.
  - For the pushbuttons, the edge detector stays in the top-level module.
- Channel FSMs, flash counter and first-out logic stay in rpsc_annunciator_ctrl.

Test Plan:
- Reset and basic latch: release reset, then raise trip_in[2] at cycle 0 with defaults.
  - ff_out = 8'h04 at cycle 7, horn = 1, first_out = 2 with valid = 1.
  - la_out[2] toggles every 16 cycles.
- Glitch rejection: pulse trip_in[5] high for 3 cycles → ff_out stays 0. A 4-cycle stable pulse → ff_out[5] = 1.
- Ack and reset sequence on channel 2:
  - lower trip_in[2], then press reset_pb → no change (still ALM_UNACK).
  - press ack_pb → la_out[2] steady 1 and horn = 0.
  - press reset_pb → ff_out = 0 and first_out_valid = 0.
- Standing trip plus simultaneous events:
  - trip_in[1] and trip_in[6] rise in the same cycle → first_out = 1.
  - assert ack_pb and reset_pb in the same cycle → both channels go to ALM_ACK and none clear.
  - reset while trip_in[6] is held high → channel 6 stays latched.
- Lamp test: with channel 3 in ALM_UNACK, assert lamp_test → la_out = 8'hFF and ff_out = 8'h08, horn unchanged. Deassert → flashing resumes.
- Async reset mid-operation: with 3 channels latched, pulse reset_from_card6_n low between clock edges → all outputs 0 immediately. After release, no alarms while trip_in = 0.
